// File: rtl/output_display_pkg.sv
// Shared constants for the output display: segment patterns (active-high gfedcba),
// converter FSM states and the double-dabble step count.
package output_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int SHIFT_CYCLES = 8;

  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles cannot occur after a conversion; map them to blank anyway.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/output_display_bin_to_bcd_serial.sv
// Sequential double-dabble: 8-bit magnitude to 3 BCD digits in SHIFT_CYCLES steps,
// followed by a one-cycle DONE. A start pulse always (re)starts the conversion.
module bin_to_bcd_serial
  import output_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mag,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  bcd_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = mag;
      bcd_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          bcd_d = {adj[10:0], sr_q[7]};
          sr_d  = {sr_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(SHIFT_CYCLES - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/output_display.sv
// CPU output register: latches the bus on OUT, converts to BCD in the background and
// scans a 4-digit multiplexed 7-segment display (sign, hundreds, tens, ones).
module output_display
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_CLOCK,
  input  logic       i_RESET_n,
  input  logic [7:0] i_BUS_DATA,
  input  logic       i_OUT_IN,
  input  logic       i_SIGNED,
  output logic [7:0] o_VALUE,
  output logic       o_BUSY,
  output logic [6:0] o_SEGMENTS,
  output logic [3:0] o_DIGIT_EN_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [7:0]    value_q, value_d;
  logic          signed_q, signed_d;
  logic [11:0]   disp_bcd_q, disp_bcd_d;
  logic          disp_sign_q, disp_sign_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  logic [7:0]  mag;
  logic        conv_busy, conv_done;
  logic [11:0] conv_bcd;
  logic [6:0]  seg;

  // -128 negates to 0x80, which is exactly the 128 we want to show.
  assign mag = (i_SIGNED && i_BUS_DATA[7]) ? (~i_BUS_DATA + 8'd1) : i_BUS_DATA;

  bin_to_bcd_serial u_conv (
    .clk   (i_CLOCK),
    .rst_n (i_RESET_n),
    .start (i_OUT_IN),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    value_d     = value_q;
    signed_d    = signed_q;
    disp_bcd_d  = disp_bcd_q;
    disp_sign_d = disp_sign_q;
    if (i_OUT_IN) begin
      value_d  = i_BUS_DATA;
      signed_d = i_SIGNED;
    end
    // The copy uses the sign latched with the value that just finished converting.
    if (conv_done) begin
      disp_bcd_d  = conv_bcd;
      disp_sign_d = signed_q && value_q[7];
    end
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      value_q     <= '0;
      signed_q    <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
    end else begin
      value_q     <= value_d;
      signed_q    <= signed_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    seg = SEG_BLANK;
    case (idx_q)
      2'd0: seg = seg_of(disp_bcd_q[3:0]);
      2'd1: seg = (BLANK_LEADING && disp_bcd_q[11:4] == 8'd0) ? SEG_BLANK
                                                             : seg_of(disp_bcd_q[7:4]);
      2'd2: seg = (BLANK_LEADING && disp_bcd_q[11:8] == 4'd0) ? SEG_BLANK
                                                             : seg_of(disp_bcd_q[11:8]);
      default: seg = disp_sign_q ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  assign o_SEGMENTS   = SEG_ACTIVE_LOW ? ~seg : seg;
  assign o_DIGIT_EN_n = ~(4'b0001 << idx_q);
  assign o_VALUE      = value_q;
  assign o_BUSY       = conv_busy;

endmodule
